// File: rtl/bsram_stream_reader_if.sv
// Byte-stream reader bus: control/status, BSRAM port-B read side and output stream.
// master = reader engine, slave = its environment (controller, RAM, stream sink).
interface bsram_stream_reader_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              ceb;
  logic              oce;
  logic [ADDR_W-1:0] adb;
  logic [7:0]        mem_dout;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;

  modport master (
    input  start, start_addr, length, mem_dout, out_ready,
    output busy, done, ceb, oce, adb, out_valid, out_data
  );

  modport slave (
    output start, start_addr, length, mem_dout, out_ready,
    input  busy, done, ceb, oce, adb, out_valid, out_data
  );
endinterface

// File: rtl/bsram_stream_reader.sv
// Read-side engine for the SDPB block RAM: fetches a run of consecutive bytes and
// presents them in address order on a valid/ready stream. Reads are only issued
// when the output FIFO is guaranteed room for them, so the fixed RAM latency can
// never overflow the FIFO under backpressure.
module bsram_stream_reader #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  bsram_stream_reader_if.master   io_bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  w_issued_inc;
  logic [READ_LATENCY-1:0] r_pipe;
  logic [READ_LATENCY-1:0] w_pipe_d;
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_inflight;
  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_drained;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop        = (r_count != '0) && io_bus.out_ready;
  assign w_push       = r_pipe[READ_LATENCY-1];
  assign w_issued_inc = r_issued + LEN_W'(1);

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pipe[i]);
    end
  end

  // A slot freed by this cycle's pop can be reused by this cycle's issue.
  assign w_credit     = (r_count + w_inflight) < (CNT_W'(FIFO_DEPTH) + CNT_W'(w_pop));
  assign w_issue      = (r_state == StIssue) && (r_issued != r_len) && w_credit;
  assign w_last_issue = w_issue && (w_issued_inc == r_len);
  // Finished once nothing is in flight and the last queued byte leaves this cycle.
  assign w_drained    = (r_pipe == '0) &&
                        ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop));

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_d = (io_bus.length == '0) ? StDone : StIssue;
        end
      end
      StIssue: if (w_last_issue) w_state_d = StDrain;
      StDrain: if (w_drained) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Transfer address and issue counter; start is only honoured in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_issued <= '0;
    end else if ((r_state == StIdle) && io_bus.start) begin
      r_addr   <= io_bus.start_addr;
      r_len    <= io_bus.length;
      r_issued <= '0;
    end else if (w_issue) begin
      r_addr   <= r_addr + ADDR_W'(1);
      r_issued <= w_issued_inc;
    end
  end

  // In-flight shift register: a bit enters on issue and exits as the data lands on mem_dout.
  always_comb begin
    w_pipe_d    = r_pipe << 1;
    w_pipe_d[0] = w_issue;
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pipe <= '0;
    else        r_pipe <= w_pipe_d;
  end

  // Output FIFO: push from the RAM pipeline, pop on stream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= io_bus.mem_dout;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign io_bus.busy      = (r_state == StIssue) || (r_state == StDrain);
  assign io_bus.done      = (r_state == StDone);
  assign io_bus.ceb       = w_issue;
  assign io_bus.oce       = (r_state != StIdle);
  assign io_bus.adb       = r_addr;
  assign io_bus.out_valid = (r_count != '0);
  assign io_bus.out_data  = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_bsram_stream_reader.sv
// Bench for bsram_stream_reader: a pipelined BSRAM model behind the DUT, a table of
// directed transfers, a reset-abort sequence and randomized transfers, all checked
// against the byte stream expected from the RAM contents.
module tb_bsram_stream_reader;

  localparam int MEM_SIZE = 8192;
  localparam int DEPTH    = 4;

  typedef struct {
    int addr;
    int len;
    int rmode;      // 0: ready always, 1: ready pattern 1,0,0,1, 2: random
    bit mid_start;  // second start (addr 100) while busy
    int exp_first;  // cycle of first accepted byte, 0 = unchecked
    int exp_done;   // cycle of done pulse, 0 = unchecked
  } vec_t;

  logic clk;
  logic rst_n;
  logic [7:0] ram [MEM_SIZE];
  logic [7:0] r_q1;
  int n_vec;
  int n_err;
  vec_t tbl [7];

  bsram_stream_reader_if #(.ADDR_W(13)) bus ();

  bsram_stream_reader #(
    .ADDR_W      (13),
    .READ_LATENCY(2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gowin SDPB port B in pipeline mode: address register, then output register gated by oce.
  always @(posedge clk) begin
    if (bus.ceb) r_q1 <= ram[bus.adb];
    if (bus.oce) bus.mem_dout <= r_q1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ceb", bus.ceb, 0);
    check("rst_oce", bus.oce, 0);
    check("rst_adb", bus.adb, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
  endtask

  function automatic logic ready_for(input int rmode, input int c);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one transfer; must be entered just after a rising edge. Cycle 0 carries start.
  task automatic run_xfer(input int addr, input int len, input int rmode, input bit mid,
                          input int exp_first, input int exp_done);
    int n_iss = 0;
    int n_acc = 0;
    int n_done = 0;
    int done_cyc = -1;
    int first_cyc = -1;
    int budget = 10 * len + 100;
    int exp_b;
    bit prev_hold = 0;
    logic [7:0] prev_data = '0;
    for (int c = 0; c < budget; c++) begin
      bus.start = (c == 0) || (mid && c == 2);
      if (c == 0) begin
        bus.start_addr = 13'(addr);
        bus.length     = 14'(len);
      end else if (mid && c == 2) begin
        bus.start_addr = 13'd100;
        bus.length     = 14'd4;
      end
      bus.out_ready = ready_for(rmode, c);
      @(negedge clk);
      if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
      end
      if (bus.ceb) begin
        check("adb", bus.adb, (addr + n_iss) % MEM_SIZE);
        n_iss++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first_cyc < 0) first_cyc = c;
        exp_b = (n_acc < len) ? int'(ram[(addr + n_acc) % MEM_SIZE]) : -1;
        check("data", bus.out_data, exp_b);
        n_acc++;
      end
      if (bus.ceb) check("credit", int'((n_iss - n_acc) <= DEPTH), 1);
      if (c == 1) check("busy", bus.busy, int'(len != 0));
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        check("done_busy", bus.busy, 0);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      @(posedge clk);
      #1;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    bus.start = 1'b0;
    check("bytes", n_acc, len);
    check("issued", n_iss, len);
    check("done_count", n_done, 1);
    if (exp_first > 0) check("first_valid", first_cyc, exp_first);
    if (exp_done > 0) check("done_cycle", done_cyc, exp_done);
  endtask

  initial begin
    int n_acc;
    int addr;
    int len;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < MEM_SIZE; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h06;
    ram[1] = 8'h07;
    ram[2] = 8'h08;
    ram[3] = 8'h09;

    // First byte 3 cycles after the accepting edge (cycle 4), done right after the last byte.
    tbl[0] = '{addr: 0,    len: 4,    rmode: 0, mid_start: 0, exp_first: 4, exp_done: 8};
    tbl[1] = '{addr: 0,    len: 4,    rmode: 1, mid_start: 0, exp_first: 0, exp_done: 0};
    tbl[2] = '{addr: 8190, len: 4,    rmode: 0, mid_start: 0, exp_first: 4, exp_done: 8};
    tbl[3] = '{addr: 0,    len: 0,    rmode: 0, mid_start: 0, exp_first: 0, exp_done: 1};
    tbl[4] = '{addr: 0,    len: 4,    rmode: 0, mid_start: 1, exp_first: 4, exp_done: 8};
    tbl[5] = '{addr: 5,    len: 8192, rmode: 0, mid_start: 0, exp_first: 4, exp_done: 8196};
    tbl[6] = '{addr: 8000, len: 300,  rmode: 2, mid_start: 0, exp_first: 0, exp_done: 0};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i].addr, tbl[i].len, tbl[i].rmode, tbl[i].mid_start,
               tbl[i].exp_first, tbl[i].exp_done);
    end

    // Reset after two bytes delivered: abort, no done, then a clean transfer.
    n_acc = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      bus.start      = (c == 0);
      bus.start_addr = 13'd0;
      bus.length     = 14'd4;
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) n_acc++;
      @(posedge clk);
      #1;
    end
    check("pre_reset_bytes", n_acc, 2);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_done", bus.done, 0);
      check("abort_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_xfer(0, 4, 0, 0, 4, 8);

    for (int k = 0; k < 20; k++) begin
      addr = $urandom_range(0, MEM_SIZE - 1);
      len  = $urandom_range(0, 40);
      run_xfer(addr, len, 2, (len > 0) && ($urandom_range(0, 1) == 1), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
